// File: rtl/cop_trng_pool_pkg.sv
// Shared definitions for the TRNG conditioning pool: FSM encodings and default sizes.
package cop_trng_pool_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int W_DEF       = 64;
    localparam int O_DEF       = 3;
    localparam int RCT_MAX_DEF = 32;

endpackage

// File: rtl/cop_vn_debias.sv
// Von Neumann debiaser: pairs raw valid bits in arrival order, emits the first bit of unequal pairs.
module cop_vn_debias
    import cop_trng_pool_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ent_bit,
    input  logic ent_vld,
    output logic d,
    output logic d_vld
);

    logic phase;
    logic first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            first <= 1'b0;
        end else if (ent_vld) begin
            phase <= ~phase;
            if (!phase) first <= ent_bit;
        end
    end

    // The second bit of a pair completes it in the same cycle it arrives.
    assign d     = first;
    assign d_vld = ent_vld & phase & (first ^ ent_bit);

endmodule

// File: rtl/cop_trng_pool.sv
// Entropy pool: debias, XOR-fold into a W-bit word, repetition-count health test,
// and a double-buffered output word handed out once per gen request.
module cop_trng_pool
    import cop_trng_pool_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int O       = O_DEF,
    parameter int RCT_MAX = RCT_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ent_bit,
    input  logic         ent_vld,
    input  logic         gen,
    output logic         rdy,
    output logic [W-1:0] rdn,
    output logic         flt
);

    localparam int CNT_W = $clog2(W * O + 1);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int RCT_W = $clog2(RCT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W * O - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [RCT_W-1:0] RCT_LIM  = RCT_W'(RCT_MAX);

    state_t           state;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             rct_last;
    logic [RCT_W-1:0] rct_cnt;
    logic             rct_trip;
    logic             d;
    logic             d_vld;

    cop_vn_debias u_debias (
        .clk     (clk),
        .rst_n   (rst_n),
        .ent_bit (ent_bit),
        .ent_vld (ent_vld),
        .d       (d),
        .d_vld   (d_vld)
    );

    // Repetition count on raw bits; a zero count means no bit seen since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rct_last <= 1'b0;
            rct_cnt  <= '0;
        end else if (ent_vld) begin
            rct_last <= ent_bit;
            if (rct_cnt != '0 && ent_bit == rct_last) begin
                if (rct_cnt != RCT_LIM) rct_cnt <= rct_cnt + 1'b1;
            end else begin
                rct_cnt <= RCT_W'(1);
            end
        end
    end

    assign rct_trip = (rct_cnt == RCT_LIM);

    // idx tracks cnt mod W so the fold needs no divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
            rdn   <= '0;
            rdy   <= 1'b0;
            flt   <= 1'b0;
        end else if (rct_trip || state == ST_FAULT) begin
            state <= ST_FAULT;
            flt   <= 1'b1;
            rdy   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            if (!gen) rdy <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (d_vld) begin
                        acc[idx] <= acc[idx] ^ d;
                        cnt      <= cnt + 1'b1;
                        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        if (cnt == CNT_LAST) state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // rdy high means this request was already served.
                    if (gen && !rdy) begin
                        rdn   <= acc;
                        rdy   <= 1'b1;
                        acc   <= '0;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_cop_trng_pool.sv
// Directed bench for cop_trng_pool: table of fold vectors plus hand-written multi-cycle sequences.
module tb_cop_trng_pool;

    logic        clk;
    logic        rst_n;
    logic        ent_bit;
    logic        ent_vld;
    logic        gen;
    logic        rdy;
    logic [63:0] rdn;
    logic        flt;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [63:0] p0;
        logic [63:0] p1;
        logic [63:0] p2;
        logic        nulls;
        logic [63:0] exp_rdn;
    } vec_t;

    vec_t vecs[7];

    cop_trng_pool dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ent_bit (ent_bit),
        .ent_vld (ent_vld),
        .gen     (gen),
        .rdy     (rdy),
        .rdn     (rdn),
        .flt     (flt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ent_bit = b;
        ent_vld = 1'b1;
        tick();
        ent_vld = 1'b0;
    endtask

    task automatic send_d(input logic b);
        send_bit(b);
        send_bit(~b);
    endtask

    task automatic send_null(input logic b);
        send_bit(b);
        send_bit(b);
    endtask

    task automatic fill_vec(input vec_t v);
        logic [63:0] word;
        logic        nb;
        nb = 1'b0;
        for (int j = 0; j < 192; j++) begin
            word = (j < 64) ? v.p0 : (j < 128) ? v.p1 : v.p2;
            if (v.nulls && (j % 16 == 0)) begin
                send_null(nb);
                nb = ~nb;
            end
            send_d(word[j % 64]);
        end
    endtask

    task automatic deliver(input logic [63:0] exp);
        gen = 1'b1;
        tick();
        check("deliver_rdy", {63'd0, rdy}, 64'd1);
        check("deliver_rdn", rdn, exp);
        gen = 1'b0;
        tick();
        check("drop_rdy", {63'd0, rdy}, 64'd0);
        check("drop_rdn_stable", rdn, exp);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic seen;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        ent_bit = 1'b0;
        ent_vld = 1'b0;
        gen     = 1'b0;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{64'h0, 64'h0, 64'h0, 1'b1, 64'h0};
        vecs[2] = '{64'h1, 64'h1, 64'h0, 1'b1, 64'h0};
        vecs[3] = '{64'h1, 64'h0, 64'h0, 1'b0, 64'h1};
        vecs[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 64'h00FF_00FF_00FF_00FF};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h0, 64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0001};

        // Power-on reset.
        tick();
        tick();
        check("reset_rdy", {63'd0, rdy}, 64'd0);
        check("reset_rdn", rdn, 64'd0);
        check("reset_flt", {63'd0, flt}, 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            fill_vec(vecs[k]);
            deliver(vecs[k].exp_rdn);
        end

        // Early request: gen high through a whole fill; stale word must stay put.
        gen  = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 192; j++) begin
            send_d(1'b0);
            if (rdy) seen = 1'b1;
        end
        check("early_rdy_low", {63'd0, seen}, 64'd0);
        check("early_rdn_stale", rdn, 64'h8000_0000_0000_0001);
        tick();
        check("early_rdy", {63'd0, rdy}, 64'd1);
        check("early_rdn", rdn, 64'h0);
        gen = 1'b0;
        tick();
        check("early_drop_rdy", {63'd0, rdy}, 64'd0);
        check("early_drop_rdn", rdn, 64'h0);

        // Asynchronous reset while rdy is held high.
        fill_vec(vecs[0]);
        gen = 1'b1;
        tick();
        check("pre_async_rdy", {63'd0, rdy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdy", {63'd0, rdy}, 64'd0);
        check("async_rdn", rdn, 64'd0);
        check("async_flt", {63'd0, flt}, 64'd0);
        gen = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-fill discards the partial word.
        for (int j = 0; j < 100; j++) send_d(1'b1);
        pulse_reset();
        gen  = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 191; j++) begin
            send_d(1'b1);
            if (rdy) seen = 1'b1;
        end
        check("midfill_rdy_low", {63'd0, seen}, 64'd0);
        send_d(1'b1);
        check("midfill_rdy_192", {63'd0, rdy}, 64'd0);
        tick();
        check("midfill_rdy", {63'd0, rdy}, 64'd1);
        check("midfill_rdn", rdn, 64'hFFFF_FFFF_FFFF_FFFF);
        gen = 1'b0;
        tick();

        // Health test: runs of 31 separated by a change must not trip.
        pulse_reset();
        for (int j = 0; j < 31; j++) send_bit(1'b1);
        send_bit(1'b0);
        for (int j = 0; j < 31; j++) send_bit(1'b1);
        tick();
        tick();
        tick();
        check("rct_31_no_flt", {63'd0, flt}, 64'd0);
        send_bit(1'b1);
        seen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (!seen) tick();
            if (flt) seen = 1'b1;
        end
        check("rct_32_flt", {63'd0, seen}, 64'd1);
        check("fault_rdy", {63'd0, rdy}, 64'd0);
        gen  = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 300; j++) begin
            send_bit(j[0]);
            if (rdy) seen = 1'b1;
        end
        check("fault_rdy_never", {63'd0, seen}, 64'd0);
        check("fault_sticky", {63'd0, flt}, 64'd1);
        gen = 1'b0;
        pulse_reset();
        check("fault_clear_flt", {63'd0, flt}, 64'd0);
        check("fault_clear_rdn", rdn, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
